// File: rtl/coproc0_timer.sv
// Coprocessor 0 for the pipelined MIPS core: SR/Cause/EPC/BadVAddr, Count/Compare timer
// with sticky TI, and device interrupts. ExcTr and rdat are combinational; all state updates
// on the next rising clock edge. There is no backpressure: mtc0 and exceptions take effect
// in the cycle they are presented.
module coproc0_timer #(
    parameter int         NUM_HWINT = 5,
    parameter int         COUNT_DIV = 2,
    parameter logic [4:0] EXC_INT   = 5'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HWINT-1:0] DevInt,
    input  logic                 PrEr,
    input  logic [31:0]          Vpc,
    input  logic                 isBD,
    input  logic [4:0]           ErCode,
    input  logic [31:0]          BadAddr,
    input  logic                 exlclr,
    output logic                 ExcTr,
    output logic [31:0]          CP0epc,
    output logic                 TimerIrq,
    input  logic                 wen,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdat,
    output logic [31:0]          rdat
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    // IM/IP slice [15:10]: bit 5 is the timer line, low bits are the device lines.
    localparam logic [5:0] IM_MASK = 6'h20 | 6'((1 << NUM_HWINT) - 1);

    logic [5:0]           im_q, im_d;
    logic                 ie_q, ie_d;
    logic                 exl_q, exl_d;
    logic                 bd_q, bd_d;
    logic                 ti_q, ti_d;
    logic [NUM_HWINT-1:0] dev_q;
    logic [4:0]           exccode_q, exccode_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          badva_q, badva_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;
    logic [PW-1:0]        presc_q, presc_d;

    logic [5:0]  ip;
    logic        int_req;
    logic        wr_sr, wr_cnt, wr_cmp, wr_epc;
    logic        tick;
    logic [31:0] count_inc;

    assign wr_sr  = wen && (addr == 5'd12);
    assign wr_cnt = wen && (addr == 5'd9);
    assign wr_cmp = wen && (addr == 5'd11);
    assign wr_epc = wen && (addr == 5'd14);

    assign tick      = (presc_q == PW'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;

    // Pending-interrupt vector: registered device lines plus the sticky timer flag.
    always_comb begin
        ip                  = '0;
        ip[NUM_HWINT-1:0]   = dev_q;
        ip[5]               = ti_q;
    end

    assign int_req = (|(ip & im_q)) & ie_q & ~exl_q;
    assign ExcTr   = (int_req | PrEr) & ~exl_q;

    // Next-state: exception entry outranks mtc0 for EXL/EPC; mtc0 Count outranks the tick.
    always_comb begin
        im_d      = wr_sr ? (wdat[15:10] & IM_MASK) : im_q;
        ie_d      = wr_sr ? wdat[0] : ie_q;
        exl_d     = exl_q;
        if (ExcTr)
            exl_d = 1'b1;
        else if (exlclr && exl_q)
            exl_d = 1'b0;
        else if (wr_sr)
            exl_d = wdat[1];
        epc_d     = ExcTr ? (isBD ? Vpc - 32'd4 : Vpc) : (wr_epc ? wdat : epc_q);
        bd_d      = ExcTr ? isBD : bd_q;
        exccode_d = ExcTr ? (int_req ? EXC_INT : ErCode) : exccode_q;
        badva_d   = (ExcTr && !int_req && (ErCode == 5'd4 || ErCode == 5'd5)) ? BadAddr : badva_q;
        compare_d = wr_cmp ? wdat : compare_q;
        count_d   = count_q;
        presc_d   = presc_q + PW'(1);
        if (wr_cnt) begin
            count_d = wdat;
            presc_d = '0;
        end else if (tick) begin
            count_d = count_inc;
            presc_d = '0;
        end
        ti_d = ti_q;
        if (wr_cmp)
            ti_d = 1'b0;
        else if (!wr_cnt && tick && (count_inc == compare_q))
            ti_d = 1'b1;
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q      <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            dev_q     <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
            badva_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            presc_q   <= '0;
        end else begin
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            dev_q     <= DevInt;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
        end
    end

    assign CP0epc   = epc_q;
    assign TimerIrq = ti_q;

    // mfc0 read mux; unmapped register numbers read zero.
    always_comb begin
        rdat = 32'd0;
        case (addr)
            5'd8:    rdat = badva_q;
            5'd9:    rdat = count_q;
            5'd11:   rdat = compare_q;
            5'd12:   rdat = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   rdat = {bd_q, ti_q, 14'd0, ip, 3'd0, exccode_q, 2'd0};
            5'd14:   rdat = epc_q;
            default: rdat = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_coproc0_timer.sv
// Directed bench for coproc0_timer: expectations are queued as stimulus is applied and
// drained (compared) once the DUT has produced the corresponding outputs.
// Clock period 20; inputs driven 1 time unit after the rising edge.
module tb_coproc0_timer;

    logic        clk;
    logic        rst;
    logic [4:0]  DevInt;
    logic        PrEr;
    logic [31:0] Vpc;
    logic        isBD;
    logic [4:0]  ErCode;
    logic [31:0] BadAddr;
    logic        exlclr;
    logic        ExcTr;
    logic [31:0] CP0epc;
    logic        TimerIrq;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;

    int errors = 0;
    int checks = 0;

    // kind: 0 = mfc0 read of register a, 1 = ExcTr, 2 = TimerIrq, 3 = CP0epc
    typedef struct {
        string       tag;
        int          kind;
        logic [4:0]  a;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    coproc0_timer #(.NUM_HWINT(5), .COUNT_DIV(2), .EXC_INT(5'd0)) dut (
        .clk(clk), .rst(rst), .DevInt(DevInt), .PrEr(PrEr), .Vpc(Vpc), .isBD(isBD),
        .ErCode(ErCode), .BadAddr(BadAddr), .exlclr(exlclr), .ExcTr(ExcTr),
        .CP0epc(CP0epc), .TimerIrq(TimerIrq), .wen(wen), .addr(addr), .wdat(wdat),
        .rdat(rdat)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wen  = 1'b1;
        addr = a;
        wdat = d;
        cyc();
        wen  = 1'b0;
    endtask

    task automatic exp_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = 0; e.a = a; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_sig(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.a = 5'd0; e.exp = v;
        sb.push_back(e);
    endtask

    // Pops every queued expectation and compares it to what the DUT shows now.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) addr = e.a;
            #1;
            case (e.kind)
                0:       obs = rdat;
                1:       obs = {31'd0, ExcTr};
                2:       obs = {31'd0, TimerIrq};
                default: obs = CP0epc;
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic exp_all_zero(input string pfx);
        logic [4:0] ra[6];
        ra = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        for (int i = 0; i < 6; i++)
            exp_rd($sformatf("%s_r%0d", pfx, ra[i]), ra[i], 32'd0);
        exp_sig({pfx, "_exctr"}, 1, 32'd0);
        exp_sig({pfx, "_ti"}, 2, 32'd0);
        exp_sig({pfx, "_epc"}, 3, 32'd0);
    endtask

    initial begin
        rst = 1'b1; DevInt = '0; PrEr = 1'b0; Vpc = '0; isBD = 1'b0; ErCode = '0;
        BadAddr = '0; exlclr = 1'b0; wen = 1'b0; addr = '0; wdat = '0;
        #3;
        exp_all_zero("reset");
        drain();
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Device interrupt on line 0 with IM10/IE enabled.
        Vpc = 32'h400; isBD = 1'b0; DevInt = 5'b00001;
        wr(5'd12, 32'h0000_0401);
        exp_sig("t1_exctr_set", 1, 32'd1);
        drain();
        cyc();
        exp_sig("t1_exctr_after", 1, 32'd0);
        exp_rd("t1_sr", 5'd12, 32'h0000_0403);
        exp_rd("t1_cause", 5'd13, 32'h0000_0400);
        exp_rd("t1_epc", 5'd14, 32'h0000_0400);
        exp_sig("t1_cp0epc", 3, 32'h0000_0400);
        drain();
        DevInt = '0; exlclr = 1'b1;
        cyc();
        exlclr = 1'b0;
        exp_rd("t1_sr_eret", 5'd12, 32'h0000_0401);
        exp_sig("t1_exctr_eret", 1, 32'd0);
        drain();

        // Precise address-error exception in a delay slot.
        PrEr = 1'b1; ErCode = 5'd4; isBD = 1'b1; Vpc = 32'h3008; BadAddr = 32'h1235;
        exp_sig("t2_exctr", 1, 32'd1);
        drain();
        cyc();
        PrEr = 1'b0; isBD = 1'b0;
        exp_rd("t2_cause", 5'd13, 32'h8000_0010);
        exp_rd("t2_epc", 5'd14, 32'h0000_3004);
        exp_rd("t2_badva", 5'd8, 32'h0000_1235);
        exp_rd("t2_sr", 5'd12, 32'h0000_0403);
        exp_sig("t2_exctr_masked", 1, 32'd0);
        drain();
        exlclr = 1'b1;
        cyc();
        exlclr = 1'b0;
        wr(5'd8, 32'h0);
        wr(5'd10, 32'hFFFF_FFFF);
        exp_rd("t2_badva_ro", 5'd8, 32'h0000_1235);
        exp_rd("t2_unmapped", 5'd10, 32'h0);
        drain();

        // Count/Compare match with COUNT_DIV=2.
        wr(5'd9, 32'h1000);
        wr(5'd11, 32'd3);
        wr(5'd9, 32'd0);
        repeat (5) cyc();
        exp_rd("t3_count2", 5'd9, 32'd2);
        exp_sig("t3_ti_before", 2, 32'd0);
        drain();
        cyc();
        exp_rd("t3_count3", 5'd9, 32'd3);
        exp_sig("t3_ti_set", 2, 32'd1);
        exp_sig("t3_no_exctr", 1, 32'd0);
        drain();
        wr(5'd11, 32'h100);
        exp_sig("t3_ti_clr", 2, 32'd0);
        drain();

        // Count wraps to 0 matching Compare=0; timer interrupt via IM15.
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        cyc();
        exp_rd("t4_count_max", 5'd9, 32'hFFFF_FFFF);
        exp_sig("t4_ti_before", 2, 32'd0);
        exp_sig("t4_exctr_before", 1, 32'd0);
        drain();
        Vpc = 32'h5000; isBD = 1'b0;
        cyc();
        exp_rd("t4_count_wrap", 5'd9, 32'd0);
        exp_sig("t4_ti_set", 2, 32'd1);
        exp_sig("t4_exctr", 1, 32'd1);
        drain();
        cyc();
        exp_sig("t4_exctr_after", 1, 32'd0);
        exp_rd("t4_sr", 5'd12, 32'h0000_8003);
        exp_rd("t4_cause", 5'd13, 32'h4000_8000);
        exp_rd("t4_epc", 5'd14, 32'h0000_5000);
        drain();
        exlclr = 1'b1;
        wr(5'd11, 32'h7FFF_0000);
        exlclr = 1'b0;
        exp_sig("t4_ti_clr", 2, 32'd0);
        exp_rd("t4_sr_eret", 5'd12, 32'h0000_8001);
        exp_sig("t4_exctr_clr", 1, 32'd0);
        drain();

        // Exception and mtc0 EPC in the same cycle: exception wins.
        Vpc = 32'h2000; isBD = 1'b0; ErCode = 5'd12; PrEr = 1'b1;
        wen = 1'b1; addr = 5'd14; wdat = 32'h1000;
        cyc();
        wen = 1'b0; PrEr = 1'b0;
        exp_rd("t5_epc", 5'd14, 32'h0000_2000);
        exp_rd("t5_cause", 5'd13, 32'h0000_0030);
        exp_rd("t5_sr", 5'd12, 32'h0000_8003);
        drain();
        exlclr = 1'b1;
        cyc();
        exlclr = 1'b0;

        // Interrupt and PrEr together; mtc0 SR in the exception cycle keeps IM/IE only.
        DevInt = 5'b00001;
        wr(5'd12, 32'h0000_8401);
        PrEr = 1'b1; ErCode = 5'd5; BadAddr = 32'hDEAD; Vpc = 32'h2400;
        exp_sig("t5_exctr", 1, 32'd1);
        drain();
        wen = 1'b1; addr = 5'd12; wdat = 32'h0000_0401;
        cyc();
        wen = 1'b0; PrEr = 1'b0;
        exp_rd("t5_sr_mix", 5'd12, 32'h0000_0403);
        exp_rd("t5_cause_int", 5'd13, 32'h0000_0400);
        exp_rd("t5_badva_keep", 5'd8, 32'h0000_1235);
        exp_rd("t5_epc_int", 5'd14, 32'h0000_2400);
        drain();

        // Asynchronous reset while EXL=1 and Count=7.
        wr(5'd9, 32'd7);
        exp_rd("t6_count7", 5'd9, 32'd7);
        drain();
        rst = 1'b1;
        exp_all_zero("t6");
        drain();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
